bram_port_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port block RAM (1-cycle registered read, write has priority over read inside the RAM) between two independent masters. Each master issues read/write requests over a valid/ready handshake; the arbiter grants at most one request per cycle, drives the RAM port, and returns read data tagged with the requester ID one cycle later. It sits between the RAM instance and the two client blocks.

---
 rtl/bram_port_arbiter.sv | 134 +++++++++++++
 tb/tb_bram_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter in front of a single-port block RAM with tagged 1-cycle read responses.
// Build option: define BRAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins conflicts).
module bram_port_arbiter #(
   parameter int unsigned RAM_WIDTH = 16,
   parameter int unsigned RAM_DEPTH = 1024,
   localparam int unsigned ADDR_W   = $clog2(RAM_DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             req_valid,
   input  logic [1:0]             req_we,
   input  logic [2*ADDR_W-1:0]    req_addr,
   input  logic [2*RAM_WIDTH-1:0] req_wdata,
   output logic [1:0]             req_ready,
   output logic                   rsp_valid,
   output logic                   rsp_id,
   output logic [RAM_WIDTH-1:0]   rsp_data,
   output logic                   ram_write_enable,
   output logic                   ram_read_enable,
   output logic [ADDR_W-1:0]      ram_address,
   output logic [RAM_WIDTH-1:0]   ram_data_in,
   input  logic [RAM_WIDTH-1:0]   ram_data_out
);

   logic [1:0]           grant;
   logic                 gnt_id;
   logic                 gnt_any;
   logic                 gnt_we;
   logic [ADDR_W-1:0]    gnt_addr;
   logic [RAM_WIDTH-1:0] gnt_wdata;

   logic pend_valid_q, pend_valid_d;
   logic pend_id_q, pend_id_d;

`ifdef BRAM_ARB_FIXED_PRIO_EN
   // Requester 0 always wins a conflict; no priority state is kept.
   always_comb begin
      grant = 2'b00;
      if (rst_n) begin
         unique case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end
`else
   logic last_grant_q, last_grant_d;

   // On conflict the requester that did not win last time is served.
   always_comb begin
      grant = 2'b00;
      if (rst_n) begin
         unique case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (gnt_any) begin
         last_grant_d = gnt_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   assign req_ready = grant;
   assign gnt_any   = |grant;
   assign gnt_id    = grant[1];

   always_comb begin
      gnt_we    = 1'b0;
      gnt_addr  = '0;
      gnt_wdata = '0;
      if (gnt_any) begin
         if (gnt_id) begin
            gnt_we    = req_we[1];
            gnt_addr  = req_addr[2*ADDR_W-1:ADDR_W];
            gnt_wdata = req_wdata[2*RAM_WIDTH-1:RAM_WIDTH];
         end else begin
            gnt_we    = req_we[0];
            gnt_addr  = req_addr[ADDR_W-1:0];
            gnt_wdata = req_wdata[RAM_WIDTH-1:0];
         end
      end
   end

   assign ram_write_enable = gnt_any && gnt_we;
   assign ram_read_enable  = gnt_any && !gnt_we;
   assign ram_address      = gnt_addr;
   assign ram_data_in      = gnt_wdata;

   // A read accepted now is answered next cycle straight from the RAM's output register.
   always_comb begin
      pend_valid_d = gnt_any && !gnt_we;
      pend_id_d    = pend_id_q;
      if (gnt_any && !gnt_we) begin
         pend_id_d = gnt_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid_q <= 1'b0;
         pend_id_q    <= 1'b0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_id_q    <= pend_id_d;
      end
   end

   assign rsp_valid = pend_valid_q;
   assign rsp_id    = pend_id_q;
   assign rsp_data  = pend_valid_q ? ram_data_out : '0;

   a_enables_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
      !(ram_write_enable && ram_read_enable));
   a_single_accept : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(req_ready));

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomised and directed bench for bram_port_arbiter against a transaction-level model.
module tb_bram_port_arbiter;

   localparam int W  = 16;
   localparam int D  = 1024;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    req_valid = '0;
   logic [1:0]    req_we = '0;
   logic [2*AW-1:0] req_addr = '0;
   logic [2*W-1:0]  req_wdata = '0;
   logic [1:0]    req_ready;
   logic          rsp_valid;
   logic          rsp_id;
   logic [W-1:0]  rsp_data;
   logic          ram_write_enable;
   logic          ram_read_enable;
   logic [AW-1:0] ram_address;
   logic [W-1:0]  ram_data_in;
   logic [W-1:0]  ram_data_out = '0;

   bram_port_arbiter #(.RAM_WIDTH(W), .RAM_DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .ram_write_enable(ram_write_enable), .ram_read_enable(ram_read_enable),
      .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
   );

   always #5 clk = ~clk;

   // Block RAM the arbiter drives: registered read, write wins.
   bit [W-1:0] ram_mem [D];
   always @(posedge clk) begin
      if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;
      else if (ram_read_enable) ram_data_out <= ram_mem[ram_address];
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Model: memory contents, who won last, and the response owed next cycle.
   bit [W-1:0] m_mem [D];
   int         m_last = 1;
   bit         m_pv = 0;
   bit         m_pid = 0;
   bit [W-1:0] m_pdata = '0;
   int         m_gnt = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_check();
      logic [1:0]    e_ready;
      logic          e_we, e_re;
      logic [AW-1:0] e_addr;
      logic [W-1:0]  e_din;
      int g;
      e_ready = '0; e_we = 0; e_re = 0; e_addr = '0; e_din = '0; g = -1;
      if (rst_n) begin
         if (req_valid == 2'b11) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
            g = 0;
`else
            g = (m_last == 0) ? 1 : 0;
`endif
         end else if (req_valid[0]) g = 0;
         else if (req_valid[1]) g = 1;
      end
      if (g >= 0) begin
         e_ready[g] = 1'b1;
         e_we   = req_we[g];
         e_re   = !req_we[g];
         e_addr = req_addr[g*AW +: AW];
         e_din  = req_wdata[g*W +: W];
      end
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("ram_we", 32'(ram_write_enable), 32'(e_we));
      chk("ram_re", 32'(ram_read_enable), 32'(e_re));
      chk("ram_addr", 32'(ram_address), 32'(e_addr));
      if (g < 0 || e_we) chk("ram_din", 32'(ram_data_in), 32'(e_din));
      if (rst_n && m_pv) begin
         chk("rsp_valid", 32'(rsp_valid), 1);
         chk("rsp_id", 32'(rsp_id), 32'(m_pid));
         chk("rsp_data", 32'(rsp_data), 32'(m_pdata));
      end else begin
         chk("rsp_valid", 32'(rsp_valid), 0);
         chk("rsp_data", 32'(rsp_data), 0);
         if (!rst_n) chk("rsp_id_rst", 32'(rsp_id), 0);
      end
      m_gnt = g;
      m_pv  = 0;
      if (!rst_n) begin
         m_last = 1;
      end else if (g >= 0) begin
         m_last = g;
         if (e_we) m_mem[e_addr] = e_din;
         else begin
            m_pv = 1; m_pid = g[0]; m_pdata = m_mem[e_addr];
         end
      end
   endtask

   task automatic drive(input bit rst, input logic [1:0] v, input logic [1:0] we,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [W-1:0] d0, input logic [W-1:0] d1);
      rst_n = rst; req_valid = v; req_we = we;
      req_addr = {a1, a0}; req_wdata = {d1, d0};
   endtask

   task automatic step(input bit rst, input logic [1:0] v, input logic [1:0] we,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [W-1:0] d0, input logic [W-1:0] d1);
      @(posedge clk);
      #1 drive(rst, v, we, a0, a1, d0, d1);
      @(negedge clk);
      model_check();
   endtask

   bit            hv [2];
   bit            hwe [2];
   logic [AW-1:0] ha [2];
   logic [W-1:0]  hd [2];

   initial begin
      // Reset: nothing granted, nothing returned.
      step(0, 2'b11, 2'b00, 10'h001, 10'h002, 0, 0);
      chk("lit_rst_ready", 32'(req_ready), 0);
      chk("lit_rst_re", 32'(ram_read_enable), 0);
      chk("lit_rst_rsp", 32'(rsp_valid), 0);
      step(1, 2'b00, 2'b00, 0, 0, 0, 0);
      chk("lit_idle_ready", 32'(req_ready), 0);

      // Write then read back through requester 0.
      step(1, 2'b01, 2'b01, 10'h005, 0, 16'h1234, 0);
      chk("lit_wr_ready", 32'(req_ready), 32'h1);
      chk("lit_wr_we", 32'(ram_write_enable), 1);
      step(1, 2'b01, 2'b00, 10'h005, 0, 0, 0);
      chk("lit_rd_re", 32'(ram_read_enable), 1);
      chk("lit_rd_norsp", 32'(rsp_valid), 0);
      step(1, 2'b00, 2'b00, 0, 0, 0, 0);
      chk("lit_raw_valid", 32'(rsp_valid), 1);
      chk("lit_raw_id", 32'(rsp_id), 0);
      chk("lit_raw_data", 32'(rsp_data), 32'h1234);

`ifndef BRAM_ARB_FIXED_PRIO_EN
      // Preload, leaving requester 1 as last winner so reads alternate 0,1,0,1.
      step(1, 2'b01, 2'b01, 10'h010, 0, 16'hAAAA, 0);
      step(1, 2'b10, 2'b10, 0, 10'h020, 0, 16'h5555);
      chk("lit_pre_ready", 32'(req_ready), 32'h2);
      for (int k = 0; k < 5; k++) begin
         if (k < 4) step(1, 2'b11, 2'b00, 10'h010, 10'h020, 0, 0);
         else step(1, 2'b00, 2'b00, 0, 0, 0, 0);
         chk("lit_rr_ready", 32'(req_ready), k < 4 ? ((k % 2) ? 32'h2 : 32'h1) : 32'h0);
         if (k >= 1) begin
            chk("lit_rr_valid", 32'(rsp_valid), 1);
            chk("lit_rr_id", 32'(rsp_id), 32'((k - 1) % 2));
            chk("lit_rr_data", 32'(rsp_data), ((k - 1) % 2) ? 32'h5555 : 32'hAAAA);
         end
      end

      // Conflict on 0x3FF right after reset: requester 0 reads the old value first.
      step(1, 2'b01, 2'b01, 10'h3FF, 0, 16'h0F0F, 0);
      step(0, 2'b00, 2'b00, 0, 0, 0, 0);
      step(1, 2'b00, 2'b00, 0, 0, 0, 0);
      step(1, 2'b11, 2'b10, 10'h3FF, 10'h3FF, 0, 16'hBEEF);
      chk("lit_cf_ready0", 32'(req_ready), 32'h1);
      step(1, 2'b11, 2'b10, 10'h3FF, 10'h3FF, 0, 16'hBEEF);
      chk("lit_cf_ready1", 32'(req_ready), 32'h2);
      chk("lit_cf_old", 32'(rsp_data), 32'h0F0F);
      step(1, 2'b01, 2'b00, 10'h3FF, 0, 0, 0);
      chk("lit_cf_nowr", 32'(rsp_valid), 0);
      step(1, 2'b00, 2'b00, 0, 0, 0, 0);
      chk("lit_cf_new", 32'(rsp_data), 32'hBEEF);
      chk("lit_cf_id", 32'(rsp_id), 0);
`else
      // Fixed priority: requester 1 waits as long as requester 0 keeps asking.
      for (int k = 0; k < 4; k++) begin
         step(1, 2'b11, 2'b00, 10'h010, 10'h020, 0, 0);
         chk("lit_fp_ready", 32'(req_ready), 32'h1);
      end
      step(1, 2'b10, 2'b00, 10'h010, 10'h020, 0, 0);
      chk("lit_fp_r1", 32'(req_ready), 32'h2);
      step(1, 2'b00, 2'b00, 0, 0, 0, 0);
`endif

      // Reset in the middle of the response cycle drops the response.
      step(1, 2'b01, 2'b00, 10'h005, 0, 0, 0);
      @(posedge clk);
      #1 drive(1, 2'b00, 2'b00, 0, 0, 0, 0);
      #1 chk("lit_mid_before", 32'(rsp_valid), 1);
      chk("lit_mid_data", 32'(rsp_data), 32'h1234);
      #1 rst_n = 1'b0;
      #1 chk("lit_mid_drop", 32'(rsp_valid), 0);
      chk("lit_mid_zero", 32'(rsp_data), 0);
      @(negedge clk);
      model_check();
      step(1, 2'b00, 2'b00, 0, 0, 0, 0);
      chk("lit_mid_after", 32'(rsp_valid), 0);
      step(1, 2'b00, 2'b00, 0, 0, 0, 0);
      chk("lit_mid_after2", 32'(rsp_valid), 0);

      // Random traffic; unaccepted requests are held stable.
      for (int i = 0; i < 2; i++) hv[i] = 0;
      for (int n = 0; n < 3000; n++) begin
         bit rst;
         rst = ($urandom_range(0, 99) != 0);
         for (int i = 0; i < 2; i++) begin
            if (!hv[i] || m_gnt == i) begin
               hv[i]  = ($urandom_range(0, 3) != 0);
               hwe[i] = ($urandom_range(0, 2) == 0);
               ha[i]  = ($urandom_range(0, 7) == 0) ? 10'h3FF : AW'($urandom_range(0, 7));
               hd[i]  = W'($urandom);
            end
         end
         step(rst, {hv[1], hv[0]}, {hwe[1], hwe[0]}, ha[0], ha[1], hd[0], hd[1]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
